// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and the rotate-priority pick used by the arbiter slice.
// Latency: n/a (types and a pure combinational function).
// Backpressure: n/a.
//
// Contents:
//   state_t   - arbiter FSM state (IDLE, BUSY)
//   rr_pick() - first requesting index scanning last_grant+1, +2 ... mod d
//
// The rr_pick request vector is sized for RR_MAX_A select bits. Narrower
// arbiters zero-extend their requests into it.
package rr_mux_arbiter_pkg;

  localparam int unsigned RR_MAX_A = 8;
  localparam int unsigned RR_MAX_D = 1 << RR_MAX_A;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Returns the first set bit of req, starting just after last_grant and
  // wrapping modulo d. When req has no set bit, last_grant is returned and the
  // caller's "any" flag must gate its use.
  function automatic int unsigned rr_pick(
    input logic [RR_MAX_D-1:0] req,
    input int unsigned         last_grant,
    input int unsigned         d
  );
    logic [RR_MAX_A-1:0] idx;
    logic                found;
    rr_pick = last_grant;
    found   = 1'b0;
    for (int unsigned i = 1; i <= RR_MAX_D; i++) begin
      idx = RR_MAX_A'((last_grant + i) % d);
      if (!found && (i <= d) && req[idx]) begin
        rr_pick = int'(idx);
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_arbiter.sv
// Combinational rotate-priority picker: lowest index after last_grant wins.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the caller decides when the grant is taken.
//
// Ports:
//   req        in   D  per-source request
//   last_grant in   A  index granted most recently (lowest priority now)
//   grant_idx  out  A  picked index (meaningful only when any=1)
//   any        out  1  at least one request present
module rr_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int A = 2,
  parameter int D = 2 ** A
) (
  input  logic [D-1:0] req,
  input  logic [A-1:0] last_grant,
  output logic [A-1:0] grant_idx,
  output logic         any
);

  logic [RR_MAX_D-1:0] req_ext;

  always_comb begin
    req_ext        = '0;
    req_ext[D-1:0] = req;
    grant_idx      = A'(rr_pick(req_ext, 32'(last_grant), D));
    any            = |req;
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Packet-aware round-robin arbiter driving a registered D:1 beat mux.
// Latency: in_valid at cycle 0 -> select at cycle 1 -> out_valid at cycle 2; then 1 beat/cycle.
// Backpressure: single-entry output register; out_valid && !out_ready drops in_ready, all holds.
//
// Build option: RR_MUX_ARBITER_WATCHDOG_EN adds an idle-beat watchdog. When the
// granted source shows no valid for TIMEOUT cycles, the grant is released and
// timeout pulses for one cycle. Without the macro, timeout is tied low.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid/in_last [D]  per-source beat valid / last beat of packet
//   in_data [D-1:0]       per-source W-bit beat
//   in_ready [D]          per-source ready (one-hot or zero)
//   select [A]            live grant index, stable for the whole packet
//   out_valid/out_last    registered output beat flags
//   out_data [W]          registered output beat
//   out_ready             downstream ready
//   timeout               watchdog release pulse
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int A       = 2,
  parameter int W       = 32,
  parameter int D       = 2 ** A,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [D-1:0] in_valid,
  input  logic [D-1:0] in_last,
  input  logic [W-1:0] in_data [D-1:0],
  output logic [D-1:0] in_ready,
  output logic [A-1:0] select,
  output logic         out_valid,
  output logic         out_last,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic         timeout
);

  if (A < 1 || A > RR_MAX_A) begin : g_bad_a
    $error("rr_mux_arbiter: A out of range");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("rr_mux_arbiter: TIMEOUT must be >= 1");
  end

  state_t       state;
  logic [A-1:0] last_grant;
  logic [A-1:0] pick_idx;
  logic         pick_any;
  logic         load_en;
  logic         accept;

  rr_arbiter #(
    .A(A),
    .D(D)
  ) u_arb (
    .req       (in_valid),
    .last_grant(last_grant),
    .grant_idx (pick_idx),
    .any       (pick_any)
  );

  // The output register can take a beat when empty or being drained this cycle.
  assign load_en = !out_valid || out_ready;
  assign accept  = (state == BUSY) && in_valid[select] && load_en;

  always_comb begin
    in_ready = '0;
    if (state == BUSY) begin
      in_ready[select] = load_en;
    end
  end

`ifdef RR_MUX_ARBITER_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            timeout_q;

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      select     <= '0;
      last_grant <= A'(D - 1);
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_data   <= '0;
`ifdef RR_MUX_ARBITER_WATCHDOG_EN
      wd_cnt     <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      // Output register: a new beat overwrites; otherwise drain on out_ready.
      if (accept) begin
        out_data  <= in_data[select];
        out_last  <= in_last[select];
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

`ifdef RR_MUX_ARBITER_WATCHDOG_EN
      timeout_q <= 1'b0;
`endif

      case (state)
        IDLE: begin
`ifdef RR_MUX_ARBITER_WATCHDOG_EN
          wd_cnt <= '0;
`endif
          if (pick_any) begin
            select <= pick_idx;
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (accept && in_last[select]) begin
            last_grant <= select;
            state      <= IDLE;
          end
`ifdef RR_MUX_ARBITER_WATCHDOG_EN
          // Only cycles where the granted source has nothing to offer count as
          // idle; downstream stalls never trip the watchdog.
          else if (!in_valid[select] && (wd_cnt == WD_W'(TIMEOUT - 1))) begin
            last_grant <= select;
            state      <= IDLE;
            timeout_q  <= 1'b1;
          end
          if (accept) begin
            wd_cnt <= '0;
          end else if (!in_valid[select]) begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
